// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port RAM between the IF fetch port
// and the MEM load/store port; data port has fixed priority over fetch.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_ack)
//   if_rdata/if_ack/if_stall      fetch data, 1-cycle completion pulse, stall
//   mem_req/mem_we/mem_addr/      data request (held until mem_ack),
//   mem_wdata                     store select, address, store data
//   mem_rdata/mem_ack/mem_stall   load data, 1-cycle completion pulse, stall
//   ram_en/ram_we/ram_addr/       RAM strobe (one cycle per access), write
//   ram_din/ram_dout              enable, address, write data, read data
//   busy                          arbiter is not idle
module unified_mem_arbiter #(
    parameter int LATENCY    = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ack,
    output logic                  mem_stall,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Counter spans 1..LATENCY, so 4 bits cover the full 1..15 range.
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;  // 1 = data port, 0 = fetch port
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           if_rdata_q, if_rdata_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    owner_d = 1'b1;
                    we_d    = mem_we;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    state_d = S_ISSUE;
                end else if (if_req) begin
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 4'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == LAT) begin
                    // Stores capture too; the requester ignores the value.
                    if (owner_q) begin
                        mem_rdata_d = ram_dout;
                    end else begin
                        if_rdata_d = ram_dout;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_en    = (state_q == S_ISSUE);
    assign ram_we    = ram_en & we_q;
    assign ram_addr  = addr_q;
    assign ram_din   = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = (state_q == S_DONE) & ~owner_q;
    assign mem_ack   = (state_q == S_DONE) & owner_q;
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: LATENCY=2 main instance plus
// LATENCY=1 and LATENCY=15 instances driven with a single load each.
module tb_unified_mem_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    // Main instance (LATENCY=2)
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, ram_dout;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_din;
    logic        if_ack, if_stall, mem_ack, mem_stall, ram_en, ram_we, busy;

    // LATENCY=1 instance
    logic        l1_req;
    logic [31:0] l1_addr, l1_ram_dout;
    logic [31:0] l1_if_rdata, l1_mem_rdata, l1_ram_addr, l1_ram_din;
    logic        l1_if_ack, l1_if_stall, l1_mem_ack, l1_mem_stall;
    logic        l1_ram_en, l1_ram_we, l1_busy;

    // LATENCY=15 instance
    logic        l15_req;
    logic [31:0] l15_addr, l15_ram_dout;
    logic [31:0] l15_if_rdata, l15_mem_rdata, l15_ram_addr, l15_ram_din;
    logic        l15_if_ack, l15_if_stall, l15_mem_ack, l15_mem_stall;
    logic        l15_ram_en, l15_ram_we, l15_busy;

    unified_mem_arbiter #(.LATENCY(2), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
    );

    unified_mem_arbiter #(.LATENCY(1), .ADDR_WIDTH(32)) dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'h0),
        .if_rdata(l1_if_rdata), .if_ack(l1_if_ack), .if_stall(l1_if_stall),
        .mem_req(l1_req), .mem_we(1'b0), .mem_addr(l1_addr),
        .mem_wdata(32'h0), .mem_rdata(l1_mem_rdata),
        .mem_ack(l1_mem_ack), .mem_stall(l1_mem_stall),
        .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_addr(l1_ram_addr),
        .ram_din(l1_ram_din), .ram_dout(l1_ram_dout), .busy(l1_busy)
    );

    unified_mem_arbiter #(.LATENCY(15), .ADDR_WIDTH(32)) dut_l15 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'h0),
        .if_rdata(l15_if_rdata), .if_ack(l15_if_ack), .if_stall(l15_if_stall),
        .mem_req(l15_req), .mem_we(1'b0), .mem_addr(l15_addr),
        .mem_wdata(32'h0), .mem_rdata(l15_mem_rdata),
        .mem_ack(l15_mem_ack), .mem_stall(l15_mem_stall),
        .ram_en(l15_ram_en), .ram_we(l15_ram_we), .ram_addr(l15_ram_addr),
        .ram_din(l15_ram_din), .ram_dout(l15_ram_dout), .busy(l15_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: read data only valid exactly LATENCY cycles after ram_en.
    logic [31:0] ram [256];
    logic [31:0] rd_data, l1_rd_data, l15_rd_data;
    int          rd_cyc = -1;
    int          l1_rd_cyc = -1;
    int          l15_rd_cyc = -1;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h00] = 32'h1111_1111;  // 0x000
        ram[8'h01] = 32'h2222_2222;  // 0x004
        ram[8'h04] = 32'h1010_1010;  // 0x010
        ram[8'h08] = 32'h2020_2020;  // 0x020
        ram[8'h10] = 32'hDEAD_BEEF;  // 0x040
        ram[8'h40] = 32'hCAFE_F00D;  // 0x100
    end

    always @(posedge clk) begin
        if (ram_en) begin
            rd_data <= ram[ram_addr[9:2]];
            rd_cyc  <= cyc + 2;
            if (ram_we) ram[ram_addr[9:2]] <= ram_din;
        end
        if (l1_ram_en) begin
            l1_rd_data <= ram[l1_ram_addr[9:2]];
            l1_rd_cyc  <= cyc + 1;
        end
        if (l15_ram_en) begin
            l15_rd_data <= ram[l15_ram_addr[9:2]];
            l15_rd_cyc  <= cyc + 15;
        end
    end

    assign ram_dout     = (cyc == rd_cyc) ? rd_data : 32'hBAD0_BAD0;
    assign l1_ram_dout  = (cyc == l1_rd_cyc) ? l1_rd_data : 32'hBAD0_BAD0;
    assign l15_ram_dout = (cyc == l15_rd_cyc) ? l15_rd_data : 32'hBAD0_BAD0;

    // Scoreboard: port 0=main IF, 1=main MEM, 2=L1 MEM, 3=L15 MEM.
    typedef struct {
        int          port;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic push(input int p, input bit c, input logic [31:0] d,
                        input int cy);
        exp_t e;
        e.port = p;
        e.chk_data = c;
        e.data = d;
        e.cyc = cy;
        sbq.push_back(e);
    endtask

    task automatic to_cycle(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic drive_at(input int t);
        while (cyc != t) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0]  acks;
    logic [31:0] rdv [4];
    assign acks   = {l15_mem_ack, l1_mem_ack, mem_ack, if_ack};
    assign rdv[0] = if_rdata;
    assign rdv[1] = mem_rdata;
    assign rdv[2] = l1_mem_rdata;
    assign rdv[3] = l15_mem_rdata;

    always @(negedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (acks[s] === 1'b1) begin
                automatic int idx = -1;
                foreach (sbq[i]) if (idx < 0 && sbq[i].port == s) idx = i;
                if (idx < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack port=%0d cycle=%0d got=ack required=none",
                             s, cyc);
                end else begin
                    chk($sformatf("ack_cycle_p%0d", s), cyc, sbq[idx].cyc);
                    if (sbq[idx].chk_data)
                        chk($sformatf("rdata_p%0d", s), rdv[s], sbq[idx].data);
                    sbq.delete(idx);
                end
            end
        end
    end

    initial begin
        int t;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        l1_req = 1'b0;
        l1_addr = '0;
        l15_req = 1'b0;
        l15_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_acks", {if_ack, mem_ack}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single load from 0x40
        @(posedge clk);
        #1;
        t = cyc;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 32'h40;
        push(1, 1'b1, 32'hDEAD_BEEF, t + 4);
        to_cycle(t);
        chk("ld_stall_c0", mem_stall, 1);
        to_cycle(t + 1);
        chk("ld_ram_en_c1", ram_en, 1);
        chk("ld_ram_addr_c1", ram_addr, 32'h40);
        chk("ld_ram_we_c1", ram_we, 0);
        to_cycle(t + 3);
        chk("ld_stall_c3", mem_stall, 1);
        to_cycle(t + 4);
        chk("ld_stall_c4", mem_stall, 0);
        drive_at(t + 5);
        mem_req = 1'b0;

        // Conflict: store 0x55AA to 0x80 beats fetch from 0x100
        @(posedge clk);
        #1;
        t = cyc;
        if_req = 1'b1;
        if_addr = 32'h100;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h80;
        mem_wdata = 32'h55AA;
        push(1, 1'b0, 32'h0, t + 4);
        push(0, 1'b1, 32'hCAFE_F00D, t + 9);
        to_cycle(t);
        chk("cf_if_stall_c0", if_stall, 1);
        to_cycle(t + 1);
        chk("cf_ram_en_c1", ram_en, 1);
        chk("cf_ram_we_c1", ram_we, 1);
        chk("cf_ram_din_c1", ram_din, 32'h55AA);
        chk("cf_ram_addr_c1", ram_addr, 32'h80);
        drive_at(t + 5);
        mem_req = 1'b0;
        mem_we = 1'b0;
        to_cycle(t + 5);
        chk("cf_ram_en_c5", ram_en, 0);
        to_cycle(t + 6);
        chk("cf_ram_en_c6", ram_en, 1);
        chk("cf_ram_addr_c6", ram_addr, 32'h100);
        chk("cf_ram_we_c6", ram_we, 0);
        to_cycle(t + 8);
        chk("cf_if_stall_c8", if_stall, 1);
        to_cycle(t + 9);
        chk("cf_if_stall_c9", if_stall, 0);
        drive_at(t + 10);
        if_req = 1'b0;

        // Back-to-back fetches 0x0 then 0x4 with if_req held
        @(posedge clk);
        #1;
        t = cyc;
        if_req = 1'b1;
        if_addr = 32'h0;
        push(0, 1'b1, 32'h1111_1111, t + 4);
        push(0, 1'b1, 32'h2222_2222, t + 9);
        to_cycle(t + 1);
        chk("bb_ram_en_c1", ram_en, 1);
        chk("bb_ram_addr_c1", ram_addr, 32'h0);
        drive_at(t + 5);
        if_addr = 32'h4;
        to_cycle(t + 5);
        chk("bb_ram_en_c5", ram_en, 0);
        to_cycle(t + 6);
        chk("bb_ram_en_c6", ram_en, 1);
        chk("bb_ram_addr_c6", ram_addr, 32'h4);
        drive_at(t + 10);
        if_req = 1'b0;

        // Reset during WAIT of a load; no ack may follow
        @(posedge clk);
        #1;
        t = cyc;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 32'h40;
        drive_at(t + 2);
        rst = 1'b1;
        mem_req = 1'b0;
        to_cycle(t + 2);
        chk("rm_busy_wait", busy, 1);
        to_cycle(t + 3);
        chk("rm_busy_after", busy, 0);
        chk("rm_mem_rdata", mem_rdata, 0);
        drive_at(t + 4);
        rst = 1'b0;
        to_cycle(t + 8);
        chk("rm_mem_rdata_late", mem_rdata, 0);
        chk("rm_busy_late", busy, 0);

        // Fresh load after reset reads back the earlier store
        @(posedge clk);
        #1;
        t = cyc;
        mem_req = 1'b1;
        mem_addr = 32'h80;
        push(1, 1'b1, 32'h0000_55AA, t + 4);
        drive_at(t + 5);
        mem_req = 1'b0;

        // Address change after grant is ignored
        @(posedge clk);
        #1;
        t = cyc;
        mem_req = 1'b1;
        mem_addr = 32'h10;
        push(1, 1'b1, 32'h1010_1010, t + 4);
        drive_at(t + 1);
        mem_addr = 32'h20;
        to_cycle(t + 1);
        chk("ac_ram_addr_c1", ram_addr, 32'h10);
        to_cycle(t + 4);
        chk("ac_ram_addr_c4", ram_addr, 32'h10);
        chk("ac_if_rdata_held", if_rdata, 0);
        drive_at(t + 5);
        mem_req = 1'b0;

        // LATENCY=1 and LATENCY=15 loads from 0x20
        @(posedge clk);
        #1;
        t = cyc;
        l1_req = 1'b1;
        l1_addr = 32'h20;
        l15_req = 1'b1;
        l15_addr = 32'h20;
        push(2, 1'b1, 32'h2020_2020, t + 3);
        push(3, 1'b1, 32'h2020_2020, t + 17);
        to_cycle(t + 1);
        chk("l1_ram_en_c1", l1_ram_en, 1);
        chk("l15_ram_en_c1", l15_ram_en, 1);
        drive_at(t + 4);
        l1_req = 1'b0;
        to_cycle(t + 16);
        chk("l15_busy_c16", l15_busy, 1);
        chk("l15_ack_c16", l15_mem_ack, 0);
        drive_at(t + 18);
        l15_req = 1'b0;

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified instruction/data RAM between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage MIPS pipeline.
- Grants one requester at a time, with the data port at fixed priority.
- Sequences each access through a small FSM and returns a one-cycle ack with read data.
- Drives per-port stall signals consumed by the pipeline controller's stage-enable logic.

Parameters:
- LATENCY, 2, cycles from the ram_en cycle to valid ram_dout; legal range 1..15.
- ADDR_WIDTH, 32, byte address width on all address ports.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  ADDR_WIDTH  fetch address.
- if_rdata  output  32  fetch data; valid while if_ack=1.
- if_ack  output  1  one-cycle fetch completion pulse.
- if_stall  output  1  if_req && !if_ack.
- mem_req  input  1  data request; held high until mem_ack.
- mem_we  input  1  1=store, 0=load.
- mem_addr  input  ADDR_WIDTH  data address.
- mem_wdata  input  32  store data.
- mem_rdata  output  32  load data; valid while mem_ack=1.
- mem_ack  output  1  one-cycle data completion pulse.
- mem_stall  output  1  mem_req && !mem_ack.
- ram_en  output  1  RAM access strobe, one cycle per access.
- ram_we  output  1  RAM write enable, meaningful only with ram_en.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_din  output  32  RAM write data.
- ram_dout  input  32  RAM read data, valid LATENCY cycles after the ram_en cycle.
- busy  output  1  state != IDLE.

Behaviour:

Reset:
- rst=1 at a clock edge forces state IDLE, counter 0, owner 0.
- Reset values: ram_en/ram_we 0, ram_addr/ram_din 0, if_rdata/mem_rdata 0, acks 0.
- Applies mid-transaction: an in-flight access is abandoned with no ack; RAM read data arriving later is ignored.

States and transitions:
- IDLE: sample requests.
  - mem_req=1: owner=DATA; latch mem_we, mem_addr, mem_wdata.
  - else if_req=1: owner=INST; latch if_addr, we=0.
  - Any grant goes to ISSUE. If neither is requesting, stay in IDLE.
- ISSUE (1 cycle): ram_en=1, ram_we/ram_addr/ram_din from the latched registers. Next state WAIT, counter=1.
- WAIT (LATENCY cycles): ram_en=0; ram_addr/ram_din hold their values.
  - When counter==LATENCY, capture ram_dout into the owner's rdata register at that edge and go to DONE.
  - Otherwise increment the counter.
- DONE (1 cycle): owner's ack=1. Next state IDLE unconditionally; requests are not sampled in DONE.

Timing:
- Request sampled in IDLE cycle 0 gives ram_en in cycle 1 and ack in cycle LATENCY+2.
- Earliest next grant is in cycle LATENCY+3.

Simultaneous and held requests:
- When both ports request in IDLE, DATA wins. IF stays stalled and is granted at the next IDLE cycle if mem_req is low then.
- An IF request never preempts an in-flight data access, and vice versa.

Store data:
- For stores, the rdata register still captures ram_dout; the requester ignores it. mem_ack marks write completion.

Requester behaviour:
- Addresses and data are latched at grant; changes while pending are ignored.
- If a requester drops req mid-transaction, the access still completes and the ack still pulses, and the pipeline discards it.

Read data and stalls:
- rdata registers hold their last captured value outside ack cycles.
- Stalls are combinational from req/ack. No X on any output after reset.

Test Plan:
- Single load, LATENCY=2: reset, then mem_req=1, mem_we=0, mem_addr=0x40, RAM returns 0xDEADBEEF → ram_en in cycle 1 with ram_addr=0x40 and ram_we=0; mem_ack and mem_rdata=0xDEADBEEF in cycle 4; mem_stall high in cycles 0-3.
- Conflict: if_req with addr 0x100 and mem_req (store 0x55AA to 0x80) asserted together → the store is issued first (ram_we=1, ram_din=0x55AA); mem_ack in cycle 4; the IF fetch is granted in cycle 5 with ram_en in cycle 6; if_ack in cycle 9; if_stall high in cycles 0-8.
- Back-to-back fetches to 0x0 and 0x4 with if_req held → two ram_en pulses 5 cycles apart; each if_ack lasts exactly one cycle; if_rdata matches per address.
- Reset mid-op: assert rst in the WAIT cycle of a load → next cycle busy=0, no mem_ack ever, mem_rdata=0; a fresh load after reset completes normally.
- LATENCY=1 build: load from 0x20 → ack in cycle 3. LATENCY=15 build: ack in cycle 17; the counter must not wrap.
- Address change after grant: mem_addr switches from 0x10 to 0x20 in cycle 1 → ram_addr stays 0x10 through DONE.
